// File: rtl/cnt_mod_updown.sv
// cnt_mod_updown: loadable up/down counter with a run-time programmable
// terminal value (modulus - 1) and a choice of wrap or saturate at the
// boundaries. It is intended as a building block for dividers, timers and
// cascaded wide counters.
//
// Parameters:
//   WIDTH    - counter, data and terminal-value width in bits (>= 2)
//   MAX_RST  - reset value of the terminal-value register
//   SATURATE - 0: wrap around at a boundary, 1: hold at the boundary
//
// Ports:
//   CLK     in   clock, rising edge
//   RST     in   asynchronous reset, active-low
//   EN      in   count/load enable
//   CLR     in   synchronous clear, active-high, independent of EN
//   LOAD    in   synchronous load, active-low, needs EN=1
//   UP      in   direction: 1 = increment, 0 = decrement
//   DATA    in   load value
//   MAX_WE  in   write strobe for the terminal-value register
//   MAX_IN  in   new terminal value
//   DOUT    out  current count
//   MAX_OUT out  current terminal value
//   COUT    out  combinational terminal count, for cascading
//   WRAP    out  registered one-cycle pulse after a boundary event
//   OVF     out  sticky boundary flag, cleared by RST or CLR
module cnt_mod_updown #(
   parameter int unsigned      WIDTH    = 8,
   parameter logic [WIDTH-1:0] MAX_RST  = {WIDTH{1'b1}},
   parameter bit               SATURATE = 1'b0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             CLR,
   input  logic             LOAD,
   input  logic             UP,
   input  logic [WIDTH-1:0] DATA,
   input  logic             MAX_WE,
   input  logic [WIDTH-1:0] MAX_IN,
   output logic [WIDTH-1:0] DOUT,
   output logic [WIDTH-1:0] MAX_OUT,
   output logic             COUT,
   output logic             WRAP,
   output logic             OVF
);

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] max_r;
   logic [WIDTH-1:0] eff_max;
   logic [WIDTH-1:0] cand;
   logic [WIDTH-1:0] q_nxt;
   logic             bnd;

   // A terminal value written this cycle already governs this cycle's
   // comparisons and clamps.
   assign eff_max = MAX_WE ? MAX_IN : max_r;

   always_comb begin
      cand = q;
      bnd  = 1'b0;
      if (EN) begin
         if (!LOAD) begin
            cand = DATA;
         end else if (UP) begin
            if (q >= eff_max) begin
               bnd  = 1'b1;
               cand = SATURATE ? eff_max : '0;
            end else begin
               cand = q + 1'b1;
            end
         end else begin
            if (q == '0) begin
               bnd  = 1'b1;
               cand = SATURATE ? '0 : eff_max;
            end else begin
               cand = q - 1'b1;
            end
         end
      end
      // Single clamp covers oversized loads, a lowered terminal value while
      // idle, and a decrement from above a freshly lowered terminal value.
      q_nxt = (cand > eff_max) ? eff_max : cand;
      if (CLR) begin
         q_nxt = '0;
         bnd   = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         q     <= '0;
         max_r <= MAX_RST;
         WRAP  <= 1'b0;
         OVF   <= 1'b0;
      end else begin
         q <= q_nxt;
         if (MAX_WE) begin
            max_r <= MAX_IN;
         end
         if (CLR) begin
            WRAP <= 1'b0;
            OVF  <= 1'b0;
         end else begin
            WRAP <= bnd;
            OVF  <= OVF | bnd;
         end
      end
   end

   assign DOUT    = q;
   assign MAX_OUT = max_r;
   // Compared against the stored terminal value and deliberately not gated
   // by EN so a cascaded upper stage can AND it with its own enable.
   assign COUT    = UP ? (q == max_r) : (q == '0);

endmodule

// File: doc/cnt_mod_updown.md
Name: cnt_mod_updown

Overview:
- Parametrised, loadable up/down counter with a run-time programmable terminal value (modulus − 1).
- Configurable wrap or saturate policy.
- Combinational terminal-count output for cascading, plus a registered boundary pulse and a sticky overflow flag.
- General-purpose timing/counting primitive for the lab designs: dividers, timers and cascaded wide counters.

Parameters:
- WIDTH, 8, counter, data and terminal-value width in bits (≥2).
- MAX_RST, {WIDTH{1'b1}}, reset value of the terminal-value register MAX_R.
- SATURATE, 0, boundary policy: 0 = wrap around, 1 = hold at the boundary.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-low.
- EN  in  1  count/load enable; when low, Q holds except for CLR and MAX clamp.
- CLR  in  1  synchronous clear, active-high; independent of EN.
- LOAD  in  1  synchronous load, active-low; effective only when EN=1.
- UP  in  1  direction: 1 = increment, 0 = decrement.
- DATA  in  WIDTH  load value.
- MAX_WE  in  1  write strobe for the terminal-value register.
- MAX_IN  in  WIDTH  new terminal value.
- DOUT  out  WIDTH  current count Q.
- MAX_OUT  out  WIDTH  current MAX_R.
- COUT  out  1  combinational terminal count: (UP & Q==MAX_R) | (!UP & Q==0); not gated by EN.
- WRAP  out  1  registered one-cycle pulse following a boundary event.
- OVF  out  1  sticky flag set by any boundary event; cleared by RST or CLR.

Behaviour:
- Reset (RST=0, asynchronous): Q=0, MAX_R=MAX_RST, WRAP=0, OVF=0. COUT then follows its equation (UP=0 gives 1).
- Effective max: M = MAX_WE ? MAX_IN : MAX_R. All same-cycle comparisons and clamps use M. If MAX_WE=1, MAX_R<=MAX_IN.
- Priority per rising edge, evaluating the next Q candidate:
  1. CLR=1: Q<=0, OVF<=0, WRAP<=0.
  2. EN=1 & LOAD=0: Q<=min(DATA, M).
  3. EN=1 & LOAD=1 & UP=1:
     - Q<M: Q<=Q+1.
     - Q>=M: boundary event; Q<=0 if SATURATE=0, else Q<=M.
  4. EN=1 & LOAD=1 & UP=0:
     - Q>0: Q<=Q−1.
     - Q==0: boundary event; Q<=M if SATURATE=0, else Q<=0.
  5. EN=0: Q holds; if MAX_WE and Q>MAX_IN, Q<=MAX_IN.
- Invariant: Q never exceeds MAX_R after any edge. Any candidate greater than M is clamped to M.
- Boundary event: WRAP<=1 for exactly the following cycle (0 otherwise) and OVF<=1. Applies in both SATURATE modes. Repeated boundary counts give WRAP high on consecutive cycles.
- No boundary event on load, clear or clamp.
- M=0: Q stays 0; every enabled count is a boundary event (WRAP high continuously while EN=1, LOAD=1).
- Arithmetic is WIDTH bits unsigned; no carry beyond WIDTH. The period in wrap mode is M+1 enabled cycles.
- Cascading: the high stage's EN = low stage's EN & COUT. The same UP drives both stages.
- Reset mid-count: immediate asynchronous return to reset values. Counting resumes on the first edge after RST deasserts.

Test Plan:
- Reset, WIDTH=8, default MAX, UP=1, EN=1: DOUT 0→255 over 255 edges (COUT=1 at 255); next edge DOUT=0, then WRAP=1 for one cycle, OVF=1.
- MAX_WE with MAX_IN=9, UP=0, from Q=0: DOUT 9,8,…,0,9 (period 10); COUT=1 while Q=0; WRAP pulses after each 0→9 transition.
- SATURATE=1, MAX=5, UP=1, 8 enabled edges from 0: DOUT 1..5 then holds 5; WRAP high on the cycles after the 6th, 7th and 8th edges; OVF sticky until CLR.
- LOAD=0 with DATA=200, MAX_R=100, EN=1: DOUT=100. LOAD=0 with EN=0: no change. CLR=1 with LOAD=0: DOUT=0.
- Q=50, EN=0, MAX_WE with MAX_IN=20: DOUT=20, MAX_OUT=20, no WRAP. Same-cycle MAX_WE (MAX_IN=30) with enabled count at Q=30: DOUT wraps to 0 and WRAP fires.
- Two cascaded WIDTH=4 instances, UP=1, count 300 edges from 0: combined value 300 mod 256 = 44 (high=2, low=12). Assert RST mid-count: both outputs 0 immediately.
